// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-way traffic light sequencer.
// Optional feature macro: PED_REQ_EN (adds the pedestrian walk phase).
package traffic_pkg;

  // Timing states of the sequencer. ST_INIT is untimed.
  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_RED_A  = 3'd1,
    ST_NS_G   = 3'd2,
    ST_NS_Y   = 3'd3,
    ST_RED_B  = 3'd4,
    ST_EW_G   = 3'd5,
    ST_EW_Y   = 3'd6
`ifdef PED_REQ_EN
    , ST_PED_WALK = 3'd7
`endif
  } state_t;

  // Sub-phase of every timed state: one LOAD cycle, then RUN until done.
  typedef enum logic {
    SUB_LOAD = 1'b0,
    SUB_RUN  = 1'b1
  } sub_t;

  // One-hot light encodings, {red,yellow,green}.
  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  // Default phase durations, in timer counts.
  localparam int DEF_WIDTH       = 8;
  localparam int DEF_GREEN_TIME  = 10;
  localparam int DEF_YELLOW_TIME = 3;
  localparam int DEF_RED_TIME    = 2;
  localparam int DEF_PED_TIME    = 6;

  // Successor of a timed state in the fixed loop (pedestrian detour is
  // decided by the controller, not here).
  function automatic state_t next_phase(input state_t s);
    state_t n;
    case (s)
      ST_INIT:     n = ST_RED_A;
      ST_RED_A:    n = ST_NS_G;
      ST_NS_G:     n = ST_NS_Y;
      ST_NS_Y:     n = ST_RED_B;
      ST_RED_B:    n = ST_EW_G;
      ST_EW_G:     n = ST_EW_Y;
      ST_EW_Y:     n = ST_RED_A;
`ifdef PED_REQ_EN
      ST_PED_WALK: n = ST_NS_G;
`endif
      default:     n = ST_INIT;
    endcase
    return n;
  endfunction

  // North-south light for a given state; red unless NS owns the road.
  function automatic logic [2:0] ns_light_of(input state_t s);
    logic [2:0] l;
    case (s)
      ST_NS_G: l = LIGHT_GRN;
      ST_NS_Y: l = LIGHT_YEL;
      default: l = LIGHT_RED;
    endcase
    return l;
  endfunction

  // East-west light for a given state; red unless EW owns the road.
  function automatic logic [2:0] ew_light_of(input state_t s);
    logic [2:0] l;
    case (s)
      ST_EW_G: l = LIGHT_GRN;
      ST_EW_Y: l = LIGHT_YEL;
      default: l = LIGHT_RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tl_phase_rom.sv
// Combinational state -> phase duration lookup for the traffic sequencer.
// Optional feature macro: PED_REQ_EN (adds the walk-phase duration).
module tl_phase_rom
  import traffic_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int GREEN_TIME  = DEF_GREEN_TIME,
  parameter int YELLOW_TIME = DEF_YELLOW_TIME,
  parameter int RED_TIME    = DEF_RED_TIME
`ifdef PED_REQ_EN
  , parameter int PED_TIME  = DEF_PED_TIME
`endif
) (
  input  state_t             state_i,
  output logic [WIDTH-1:0]   duration_o
);

  // Durations are taken modulo 2**WIDTH; the controller rejects values
  // that would not fit at elaboration.
  localparam logic [WIDTH-1:0] GREEN_W  = WIDTH'(GREEN_TIME);
  localparam logic [WIDTH-1:0] YELLOW_W = WIDTH'(YELLOW_TIME);
  localparam logic [WIDTH-1:0] RED_W    = WIDTH'(RED_TIME);
`ifdef PED_REQ_EN
  localparam logic [WIDTH-1:0] PED_W    = WIDTH'(PED_TIME);
`endif

  // Map each timed state to its duration; the untimed INIT maps to 0.
  always_comb begin
    duration_o = '0;
    case (state_i)
      ST_RED_A, ST_RED_B: duration_o = RED_W;
      ST_NS_G,  ST_EW_G:  duration_o = GREEN_W;
      ST_NS_Y,  ST_EW_Y:  duration_o = YELLOW_W;
`ifdef PED_REQ_EN
      ST_PED_WALK:        duration_o = PED_W;
`endif
      default:            duration_o = '0;
    endcase
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-way (NS/EW) intersection sequencer; master of a countdown timer.
// Optional feature macro: PED_REQ_EN (ped_req/ped_walk ports, walk phase
// inserted after RED_A when a request is pending).
//
// Timer protocol: the controller issues a one-cycle tmr_load with
// tmr_load_value = phase duration, then holds tmr_enable = ctrl_en while
// the phase runs. tmr_done is a level (count == 0); it is only honoured in
// the RUN sub-phase, because on the LOAD cycle the timer still shows the
// done from the phase that just ended. A phase of duration N therefore
// takes N+2 cycles with ctrl_en held high.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int GREEN_TIME  = DEF_GREEN_TIME,
  parameter int YELLOW_TIME = DEF_YELLOW_TIME,
  parameter int RED_TIME    = DEF_RED_TIME,
  parameter int PED_TIME    = DEF_PED_TIME
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ctrl_en,
  input  logic             tmr_done,
  output logic             tmr_load,
  output logic             tmr_enable,
  output logic [WIDTH-1:0] tmr_load_value,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
`ifdef PED_REQ_EN
  input  logic             ped_req,
  output logic             ped_walk,
`endif
  output state_t           dbg_state
);

  // Reject durations of zero or too wide for the timer.
  if (WIDTH < 1) begin : g_bad_width
    $error("traffic_light_ctrl: WIDTH must be at least 1");
  end
  if (GREEN_TIME < 1 || (GREEN_TIME >> WIDTH) != 0) begin : g_bad_green
    $error("traffic_light_ctrl: GREEN_TIME must be in 1..2**WIDTH-1");
  end
  if (YELLOW_TIME < 1 || (YELLOW_TIME >> WIDTH) != 0) begin : g_bad_yellow
    $error("traffic_light_ctrl: YELLOW_TIME must be in 1..2**WIDTH-1");
  end
  if (RED_TIME < 1 || (RED_TIME >> WIDTH) != 0) begin : g_bad_red
    $error("traffic_light_ctrl: RED_TIME must be in 1..2**WIDTH-1");
  end
  if (PED_TIME < 1 || (PED_TIME >> WIDTH) != 0) begin : g_bad_ped
    $error("traffic_light_ctrl: PED_TIME must be in 1..2**WIDTH-1");
  end

  state_t           state_q, state_d;
  sub_t             sub_q, sub_d;
  logic [WIDTH-1:0] dur_d;
  logic             in_run;
  logic             exit_run;

  logic             tmr_load_q;
  logic [WIDTH-1:0] tmr_load_value_q;
  logic [2:0]       ns_light_q;
  logic [2:0]       ew_light_q;

`ifdef PED_REQ_EN
  logic             pend_q, pend_d;
  logic             ped_walk_q;
`endif

  // Duration of the state being entered, used to register the load value.
  tl_phase_rom #(
    .WIDTH       (WIDTH),
    .GREEN_TIME  (GREEN_TIME),
    .YELLOW_TIME (YELLOW_TIME),
    .RED_TIME    (RED_TIME)
`ifdef PED_REQ_EN
    , .PED_TIME  (PED_TIME)
`endif
  ) u_phase_rom (
    .state_i    (state_d),
    .duration_o (dur_d)
  );

  assign in_run   = (state_q != ST_INIT) && (sub_q == SUB_RUN);
  assign exit_run = in_run && tmr_done && ctrl_en;

  // Next-state: INIT falls through, LOAD always advances to RUN, RUN
  // leaves only on done with the controller enabled.
  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
`ifdef PED_REQ_EN
    pend_d  = pend_q | ped_req;
`endif
    if (state_q == ST_INIT) begin
      state_d = ST_RED_A;
      sub_d   = SUB_LOAD;
    end else if (sub_q == SUB_LOAD) begin
      sub_d   = SUB_RUN;
    end else if (exit_run) begin
      sub_d   = SUB_LOAD;
      state_d = next_phase(state_q);
`ifdef PED_REQ_EN
      // A pending request detours RED_A through the walk phase; the
      // request is consumed by entering it.
      if (state_q == ST_RED_A && pend_q) begin
        state_d = ST_PED_WALK;
        pend_d  = 1'b0;
      end
`endif
    end
  end

  // State, sub-phase and registered Moore outputs, all derived from the
  // state being entered so they line up with the registered state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q          <= ST_INIT;
      sub_q            <= SUB_LOAD;
      tmr_load_q       <= 1'b0;
      tmr_load_value_q <= '0;
      ns_light_q       <= LIGHT_RED;
      ew_light_q       <= LIGHT_RED;
`ifdef PED_REQ_EN
      pend_q           <= 1'b0;
      ped_walk_q       <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      sub_q            <= sub_d;
      tmr_load_q       <= (state_d != ST_INIT) && (sub_d == SUB_LOAD);
      tmr_load_value_q <= ((state_d != ST_INIT) && (sub_d == SUB_LOAD)) ? dur_d : '0;
      ns_light_q       <= ns_light_of(state_d);
      ew_light_q       <= ew_light_of(state_d);
`ifdef PED_REQ_EN
      pend_q           <= pend_d;
      ped_walk_q       <= (state_d == ST_PED_WALK);
`endif
    end
  end

  // The count enable follows ctrl_en directly so the timer freezes on the
  // same cycles the state holds.
  assign tmr_enable     = in_run && ctrl_en;
  assign tmr_load       = tmr_load_q;
  assign tmr_load_value = tmr_load_value_q;
  assign ns_light       = ns_light_q;
  assign ew_light       = ew_light_q;
  assign dbg_state      = state_q;
`ifdef PED_REQ_EN
  assign ped_walk       = ped_walk_q;
`endif

endmodule
